// File: rtl/bp_cache_sa.sv
// Set-associative branch-predictor cache with two combinational lookup ports,
// one write/allocate port, per-set true-LRU replacement and a one-set-per-cycle
// flush sequencer.
module bp_cache_sa #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int LINES  = 128,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] ra0,
  output logic [DWIDTH-1:0] dout0,
  output logic              hit0,
  input  logic [AWIDTH-1:0] ra1,
  output logic [DWIDTH-1:0] dout1,
  output logic              hit1,
  input  logic [AWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] din,
  input  logic              we,
  input  logic              flush,
  output logic              busy
);

  localparam int SETS  = LINES / WAYS;
  localparam int IBITS = $clog2(SETS);
  localparam int IW    = (IBITS > 0) ? IBITS : 1;
  localparam int TBITS = AWIDTH - 2 - IBITS;
  localparam int ABITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [WAYS-1:0][ABITS-1:0] ages_t;

  typedef struct packed {
    logic              hit;
    logic [ABITS-1:0]  way;
    logic [DWIDTH-1:0] data;
  } look_t;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   valid_d [SETS];
  ages_t             age_q   [SETS];
  ages_t             age_d   [SETS];
  logic [TBITS-1:0]  tag_mem  [SETS][WAYS];
  logic [DWIDTH-1:0] data_mem [SETS][WAYS];

  logic              unused_addr_lsbs;
  assign unused_addr_lsbs = ^{ra0[1:0], ra1[1:0], wa[1:0]};

  function automatic logic [IW-1:0] idx_of(input logic [AWIDTH-1:0] a);
    idx_of = IW'((a >> 2) & AWIDTH'(SETS - 1));
  endfunction

  function automatic logic [TBITS-1:0] tag_of(input logic [AWIDTH-1:0] a);
    tag_of = TBITS'(a >> (2 + IBITS));
  endfunction

  function automatic look_t lookup(input logic [AWIDTH-1:0] a);
    logic [IW-1:0] i;
    i = idx_of(a);
    lookup = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[i][w] && tag_mem[i][w] == tag_of(a)) begin
        lookup.hit  = 1'b1;
        lookup.way  = ABITS'(w);
        lookup.data = data_mem[i][w];
      end
    end
  endfunction

  // Touching way k: younger ways age by one, k becomes MRU.
  function automatic ages_t touch(input ages_t a, input logic [ABITS-1:0] k);
    touch = a;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (a[w] < a[k]) touch[w] = a[w] + 1'b1;
    end
    touch[k] = '0;
  endfunction

  look_t            lk0, lk1, lkw;
  logic [IW-1:0]    ri0, wi;
  logic [ABITS-1:0] wway;
  logic             wr_en, rd_touch;

  assign busy = (state_q == S_FLUSH);

  // Combinational lookups, gated off while a flush sweep is running.
  always_comb begin
    lk0   = lookup(ra0);
    lk1   = lookup(ra1);
    lkw   = lookup(wa);
    ri0   = idx_of(ra0);
    wi    = idx_of(wa);
    hit0  = lk0.hit && !busy;
    hit1  = lk1.hit && !busy;
    dout0 = hit0 ? lk0.data : '0;
    dout1 = hit1 ? lk1.data : '0;
  end

  // Write way: matching way, else lowest invalid way, else the LRU way.
  always_comb begin
    logic found;
    wway  = '0;
    found = 1'b0;
    if (lkw.hit) begin
      wway = lkw.way;
    end else begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (!found && !valid_q[wi][w]) begin
          wway  = ABITS'(w);
          found = 1'b1;
        end
      end
      if (!found) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (age_q[wi][w] == ABITS'(WAYS - 1)) wway = ABITS'(w);
        end
      end
    end
  end

  assign wr_en    = (state_q == S_IDLE) && we && !flush;
  assign rd_touch = hit0 && !(wr_en && (wi == ri0));

  // Next-state: flush FSM, valid bits and LRU ages.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    age_d   = age_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else begin
          if (rd_touch) age_d[ri0] = touch(age_q[ri0], lk0.way);
          // Write touch is computed from pre-edge ages, so in a shared set it
          // replaces the read touch rather than compounding with it.
          if (wr_en) begin
            valid_d[wi][wway] = 1'b1;
            age_d[wi]         = touch(age_q[wi], wway);
          end
        end
      end
      S_FLUSH: begin
        valid_d[cnt_q] = '0;
        for (int unsigned w = 0; w < WAYS; w++) age_d[cnt_q][w] = ABITS'(w);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IW'(SETS - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: asynchronously reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) age_q[s][w] <= ABITS'(w);
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

  // Tag/data storage: not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wi][wway]  <= tag_of(wa);
      data_mem[wi][wway] <= din;
    end
  end

endmodule

// File: tb/tb_bp_cache_sa.sv
// Directed bench for bp_cache_sa with LINES=128, WAYS=2 (64 sets).
module tb_bp_cache_sa;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ra0, ra1, wa, din, dout0, dout1;
  logic        hit0, hit1, we, flush, busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bp_cache_sa #(.AWIDTH(32), .DWIDTH(32), .LINES(128), .WAYS(2)) dut (
    .clk(clk), .reset(reset),
    .ra0(ra0), .dout0(dout0), .hit0(hit0),
    .ra1(ra1), .dout1(dout1), .hit1(hit1),
    .wa(wa), .din(din), .we(we),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wa  = a;
    din = d;
    we  = 1'b1;
    tick();
    we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned nbusy;
    reset = 1'b0; we = 1'b0; flush = 1'b0;
    ra0 = 32'h010; ra1 = 32'h020; wa = '0; din = '0;
    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_hit0", hit0, 0);
    check_eq("rst_dout0", dout0, 0);
    check_eq("rst_hit1", hit1, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // 1: basic hits and a miss
    ra0 = 32'h040;
    wr(32'h010, 32'hDEADBEEF);
    wr(32'h020, 32'hCAFEBABE);
    ra0 = 32'h010; ra1 = 32'h020; #1;
    check_eq("t1_hit0", hit0, 1);
    check_eq("t1_dout0", dout0, 32'hDEADBEEF);
    check_eq("t1_hit1", hit1, 1);
    check_eq("t1_dout1", dout1, 32'hCAFEBABE);
    ra0 = 32'h040; #1;
    check_eq("t1_miss_hit0", hit0, 0);
    check_eq("t1_miss_dout0", dout0, 0);

    // 2: conflict in set 4; port-0 read makes A MRU so B is the victim
    wr(32'h010, 32'h0000000A);
    wr(32'h110, 32'h0000000B);
    ra0 = 32'h010;
    tick();
    ra0 = 32'h040;
    wr(32'h210, 32'h0000000C);
    ra0 = 32'h110; #1;
    check_eq("t2_evicted_hit", hit0, 0);
    ra0 = 32'h010; #1;
    check_eq("t2_a_hit", hit0, 1);
    check_eq("t2_a_data", dout0, 32'h0000000A);
    ra0 = 32'h210; #1;
    check_eq("t2_c_hit", hit0, 1);
    check_eq("t2_c_data", dout0, 32'h0000000C);
    ra0 = 32'h040; #1;

    // 3: write-hit overwrites in place
    wr(32'h010, 32'h11111111);
    wr(32'h010, 32'h22222222);
    ra0 = 32'h010; ra1 = 32'h210; #1;
    check_eq("t3_hit", hit0, 1);
    check_eq("t3_data", dout0, 32'h22222222);
    check_eq("t3_c_kept", dout1, 32'h0000000C);
    ra0 = 32'h110; #1;
    check_eq("t3_no_alloc", hit0, 0);
    ra0 = 32'h040;

    // 4: no same-cycle bypass
    ra1 = 32'h030;
    wa = 32'h030; din = 32'h12345678; we = 1'b1; #1;
    check_eq("t4_during_hit1", hit1, 0);
    tick();
    we = 1'b0;
    check_eq("t4_after_hit1", hit1, 1);
    check_eq("t4_after_dout1", dout1, 32'h12345678);

    // 5: flush sweep; a write issued while busy is dropped
    ra0 = 32'h010; ra1 = 32'h020;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 200) begin
      nbusy++;
      if (nbusy == 3) begin
        check_eq("t5_busy_hit0", hit0, 0);
        check_eq("t5_busy_hit1", hit1, 0);
      end
      if (nbusy == 5) begin
        wa = 32'h050; din = 32'h55555555; we = 1'b1;
      end else begin
        we = 1'b0;
      end
      tick();
    end
    we = 1'b0;
    check_eq("t5_busy_cycles", nbusy, 64);
    ra0 = 32'h010; ra1 = 32'h020; #1;
    check_eq("t5_post_hit0", hit0, 0);
    check_eq("t5_post_hit1", hit1, 0);
    ra0 = 32'h210; ra1 = 32'h030; #1;
    check_eq("t5_post_c", hit0, 0);
    check_eq("t5_post_30", hit1, 0);
    ra0 = 32'h050; #1;
    check_eq("t5_dropped_wr", hit0, 0);
    wr(32'h060, 32'h66666666);
    ra0 = 32'h060; #1;
    check_eq("t5_new_hit", hit0, 1);
    check_eq("t5_new_data", dout0, 32'h66666666);

    // 6: reset mid-flush aborts the sweep
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (10) tick();
    check_eq("t6_busy_pre", busy, 1);
    ra0 = 32'h060; ra1 = 32'h060;
    reset = 1'b0; #1;
    check_eq("t6_busy_rst", busy, 0);
    check_eq("t6_hit0_rst", hit0, 0);
    check_eq("t6_hit1_rst", hit1, 0);
    tick();
    reset = 1'b1;
    tick();
    ra0 = 32'h040;
    wr(32'h070, 32'h77777777);
    ra1 = 32'h070; #1;
    check_eq("t6_wr_hit", hit1, 1);
    check_eq("t6_wr_data", dout1, 32'h77777777);
    repeat (5) tick();
    check_eq("t6_no_sweep", busy, 0);
    check_eq("t6_still_hit", hit1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
